// File: rtl/shr_ctrl_pkg.sv
// Shared types and defaults for the Shr arbiter/sequencer slice.
package shr_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_TAG_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Counter must hold 0..WIDTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/shr_rr_arbiter.sv
// Two-way round-robin arbiter; on a tie the requester that was not granted last wins.
module shr_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = '0;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/shr_seq_arbiter.sv
// Arbitrates two requesters onto an iterative one-bit-per-cycle logical shift-right
// unit with taint propagation, returning results on a single ID-tagged channel.
module shr_seq_arbiter
  import shr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [TAG_W-1:0] req0_a_t,
  input  logic [TAG_W-1:0] req0_b_t,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_a_t,
  input  logic [TAG_W-1:0] req1_b_t,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic [TAG_W-1:0] rsp_c_t,
  output logic             busy
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] W_LIM = WIDTH[WIDTH-1:0];

  state_t           state, state_n;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [1:0]       grant;
  logic             enable;
  logic             accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [TAG_W-1:0] sel_at, sel_bt;
  logic [CW-1:0]    b_clamp;

  // Ready is gated by reset so no requester sees a handshake while rst_n is low.
  assign enable = (state == IDLE) && rst_n;
  assign accept = |grant;

  shr_rr_arbiter u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .enable (enable),
    .accept (accept),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    sel_a   = grant[1] ? req1_a   : req0_a;
    sel_b   = grant[1] ? req1_b   : req0_b;
    sel_at  = grant[1] ? req1_a_t : req0_a_t;
    sel_bt  = grant[1] ? req1_b_t : req0_b_t;
    b_clamp = (sel_b >= W_LIM) ? CW'(WIDTH) : CW'(sel_b);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)    state_n = SHIFT;
      SHIFT:   if (cnt == '0) state_n = DONE;
      DONE:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      rsp_c   <= '0;
      rsp_c_t <= '0;
      rsp_id  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (accept) begin
            acc     <= sel_a;
            cnt     <= b_clamp;
            rsp_c_t <= sel_at | sel_bt;
            rsp_id  <= grant[1];
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            rsp_c <= acc;
          end else begin
            acc <= acc >> 1;
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shr_seq_arbiter.sv
// Directed self-checking bench for shr_seq_arbiter.
module tb_shr_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0] req0_a_t = '0, req0_b_t = '0, req1_a_t = '0, req1_b_t = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
  logic [3:0]  rsp_c;
  logic [31:0] rsp_c_t;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shr_seq_arbiter #(.WIDTH(4), .TAG_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_a_t(req0_a_t), .req0_b_t(req0_b_t),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_a_t(req1_a_t), .req1_b_t(req1_b_t),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_c_t(rsp_c_t), .busy(busy)
  );

  // Present an operation and hold valid until accepted; returns just after the accept edge.
  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b,
                       input logic [31:0] at, input logic [31:0] bt, output bit ok);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_a_t = at; req0_b_t = bt;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_a_t = at; req1_b_t = bt;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id == 1'b0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until rsp_valid is seen; ends at a negedge.
  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        fails++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
      end
      tests++;
      if ({rsp_valid, busy, rsp_id, rsp_c, rsp_c_t} !== '0) begin
        fails++; $display("FAIL reset_rsp got v=%b busy=%b id=%b c=%h ct=%h want all 0",
                          rsp_valid, busy, rsp_id, rsp_c, rsp_c_t);
      end
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_basic_shift();
    bit ok; int n;
    issue(1'b0, 4'b1101, 4'd2, 32'h0, 32'h0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_accept got no ready want ready"); end
    wait_rsp(n);
    tests++;
    if (n != 3) begin fails++; $display("FAIL basic_latency got %0d want 3", n); end
    tests++;
    if (rsp_c !== 4'b0011) begin fails++; $display("FAIL basic_c got %b want 0011", rsp_c); end
    tests++;
    if (rsp_c_t !== 32'h0 || rsp_id !== 1'b0) begin
      fails++; $display("FAIL basic_tag_id got ct=%h id=%b want ct=0 id=0", rsp_c_t, rsp_id);
    end
    consume();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL basic_idle got busy=%b v=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_taint_zero_shift();
    bit ok; int n;
    @(posedge clk); #1;
    issue(1'b1, 4'b1010, 4'd0, 32'h1, 32'h100, ok);
    wait_rsp(n);
    tests++;
    if (!ok || n != 1) begin fails++; $display("FAIL taint_latency got ok=%0d n=%0d want 1 1", ok, n); end
    tests++;
    if (rsp_c !== 4'b1010) begin fails++; $display("FAIL taint_c got %b want 1010", rsp_c); end
    tests++;
    if (rsp_c_t !== 32'h101) begin fails++; $display("FAIL taint_ct got %h want 00000101", rsp_c_t); end
    tests++;
    if (rsp_id !== 1'b1) begin fails++; $display("FAIL taint_id got %b want 1", rsp_id); end
    consume();
  endtask

  task automatic test_clamp();
    bit ok; int n;
    issue(1'b0, 4'hF, 4'd15, 32'h0, 32'h0, ok);
    wait_rsp(n);
    tests++;
    if (!ok || n != 5) begin fails++; $display("FAIL clamp_latency got ok=%0d n=%0d want 1 5", ok, n); end
    tests++;
    if (rsp_c !== 4'h0 || rsp_c_t !== 32'h0) begin
      fails++; $display("FAIL clamp_c got c=%h ct=%h want 0 0", rsp_c, rsp_c_t);
    end
    consume();
  endtask

  task automatic test_fairness();
    int g, r, cyc, both_hi, overlap;
    bit gid[4];
    int gcyc[4];
    bit rid[4];
    logic [3:0] rc[4];
    // Fresh reset so requester 0 wins the first tie.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_a = 4'h8; req0_b = 4'd1; req0_a_t = 32'h0; req0_b_t = 32'h0;
    req1_a = 4'hC; req1_b = 4'd2; req1_a_t = 32'h0; req1_b_t = 32'h0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    g = 0; r = 0; cyc = 0; both_hi = 0; overlap = 0;
    while ((g < 4 || r < 4) && cyc < 100) begin
      @(negedge clk);
      if (rsp_valid && r < 4) begin rid[r] = rsp_id; rc[r] = rsp_c; r++; end
      if (req0_ready && req1_ready) both_hi++;
      if (rsp_valid && (req0_ready || req1_ready)) overlap++;
      if ((req0_ready || req1_ready) && g < 4) begin gid[g] = req1_ready; gcyc[g] = cyc; g++; end
      @(posedge clk); #1;
      if (g == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      cyc++;
    end
    rsp_ready = 1'b0;
    tests++;
    if (g != 4 || r != 4) begin fails++; $display("FAIL fair_timeout got g=%0d r=%0d want 4 4", g, r); end
    tests++;
    if ({gid[0], gid[1], gid[2], gid[3]} !== 4'b0101 || {rid[0], rid[1], rid[2], rid[3]} !== 4'b0101) begin
      fails++; $display("FAIL fair_order got grants=%b%b%b%b ids=%b%b%b%b want 0101 0101",
                        gid[0], gid[1], gid[2], gid[3], rid[0], rid[1], rid[2], rid[3]);
    end
    tests++;
    if (rc[0] !== 4'h4 || rc[1] !== 4'h3 || rc[2] !== 4'h4 || rc[3] !== 4'h3) begin
      fails++; $display("FAIL fair_c got %h %h %h %h want 4 3 4 3", rc[0], rc[1], rc[2], rc[3]);
    end
    tests++;
    if (gcyc[1] - gcyc[0] != 4 || gcyc[2] - gcyc[1] != 5 || gcyc[3] - gcyc[2] != 4) begin
      fails++; $display("FAIL fair_spacing got %0d %0d %0d want 4 5 4",
                        gcyc[1] - gcyc[0], gcyc[2] - gcyc[1], gcyc[3] - gcyc[2]);
    end
    tests++;
    if (both_hi != 0 || overlap != 0) begin
      fails++; $display("FAIL fair_onehot got both=%0d overlap=%0d want 0 0", both_hi, overlap);
    end
  endtask

  task automatic test_backpressure_reset();
    bit ok; int n, bad, seen;
    @(posedge clk); #1;
    issue(1'b1, 4'h6, 4'd1, 32'hA, 32'h50, ok);
    wait_rsp(n);
    tests++;
    if (!ok || n != 2) begin fails++; $display("FAIL bp_latency got ok=%0d n=%0d want 1 2", ok, n); end
    req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'd3; req0_a_t = 32'h0; req0_b_t = 32'h0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_c !== 4'h3 || rsp_c_t !== 32'h5A || rsp_id !== 1'b1 || req0_ready !== 1'b0)
        bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req0_ready !== 1'b0) begin fails++; $display("FAIL bp_handshake_ready got %b want 0", req0_ready); end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b1) begin fails++; $display("FAIL bp_next_grant got %b want 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b want 1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL mid_reset_rsp got %0d active cycles want 0", seen); end
    tests++;
    if (rsp_c !== 4'h0 || rsp_c_t !== 32'h0 || rsp_id !== 1'b0) begin
      fails++; $display("FAIL mid_reset_regs got c=%h ct=%h id=%b want 0 0 0", rsp_c, rsp_c_t, rsp_id);
    end
  endtask

  initial begin
    test_reset();
    test_basic_shift();
    test_taint_zero_shift();
    test_clamp();
    test_fairness();
    test_backpressure_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shr_seq_arbiter.md
# shr_seq_arbiter

Two-requester arbiter and sequencer in front of a shared, iterative logical shift-right unit with taint tracking. Each accepted request yields `c = a >> b` in the DuRTL Shr style: 4-bit data plus a 32-bit taint tag per operand. The result comes back on a single response channel tagged with the requester ID. The block sits between the Shr datapath and its clients: it serialises access, runs the shift one bit per cycle, and propagates taint.

## Interface
- `WIDTH`, 4, data width of `a`, `b`, `c`
- `TAG_W`, 32, taint tag width of `a_t`, `b_t`, `c_t`
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `req0_valid` in 1: requester 0 has an operation
- `req0_ready` out 1: requester 0 accepted this cycle
- `req0_a`, `req0_b` in WIDTH: operand and shift amount
- `req0_a_t`, `req0_b_t` in TAG_W: operand taint tags
- `req1_*`: identical set for requester 1
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: consumer takes result
- `rsp_id` out 1: requester that issued the result
- `rsp_c` out WIDTH: shifted result
- `rsp_c_t` out TAG_W: result taint
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If any `reqN_valid` is high, the arbiter grants one requester.
  - `reqN_ready` is combinational: high only in IDLE, for the granted N.
  - On `valid & ready`, the block captures:
    - `acc <= a`
    - `cnt <= min(b, WIDTH)`
    - `rsp_c_t <= a_t | b_t`
    - `rsp_id <= N`
  - Next state is SHIFT.
- **Arbitration:**
  - A single valid requester wins.
  - If both are valid, the requester ≠ `last_grant` wins (round-robin).
  - `last_grant` updates on accept.
- **SHIFT:**
  - If `cnt == 0`: `rsp_c <= acc`, go to DONE.
  - Otherwise: `acc <= acc >> 1` (zero fill), `cnt <= cnt - 1`.
- **DONE:**
  - `rsp_valid = 1`; `rsp_c`, `rsp_c_t` and `rsp_id` are held stable.
  - On `rsp_ready`, go to IDLE.
  - No request is accepted in the DONE→IDLE handshake cycle.
- **Taint:**
  - `rsp_c_t` is the bitwise OR of both operand tags, independent of data values.
  - An untainted request (both tags 0) always gives `rsp_c_t = 0`.
- **`b >= WIDTH`:** the count is clamped to WIDTH, so the result is 0 and latency is bounded.
- **Request drop:** a requester deasserting valid before ready is not an error; nothing is captured.

## Timing
- **Reset values (any `rst_n` low at a rising edge):**
  - state = IDLE, `last_grant` = 1 (requester 0 wins the first tie)
  - `rsp_valid` = 0, `rsp_c` = 0, `rsp_c_t` = 0, `rsp_id` = 0
  - `busy` = 0, both `ready` = 0
- **Latency:** accept at edge k gives `rsp_valid` rising after edge k + min(b, WIDTH) + 1. Examples: b=0 → k+1; b=3 → k+4; b=9 → k+5.
- **Response hold:** `rsp_valid` stays high until a cycle with `rsp_ready` = 1; the state is IDLE after that edge.
- **Throughput:** back-to-back operations take at least min(b, WIDTH) + 3 cycles each; acceptance is earliest in the cycle after the response handshake.
- **Reset mid-operation:** the in-flight operation is discarded and no response is issued. The requester must re-issue.
- **Simultaneous requests:** only one `ready` is high per cycle. The loser keeps valid asserted and is granted on the next IDLE.

## Structure
- **`shr_ctrl_pkg`:**
  - state enum (IDLE/SHIFT/DONE)
  - default `WIDTH`/`TAG_W` localparams
  - count width `$clog2(WIDTH+1)`
- **`shr_rr_arbiter` sub-module:** 2-way round-robin.
  - Inputs: `valid[1:0]`, `enable`, `accept`.
  - Outputs: one-hot `grant`; holds `last_grant`.
- **Top level:** FSM, shift accumulator, counter, response registers.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with both requesters valid. Required: `ready` = 0, `rsp_*` = 0, `busy` = 0 throughout.
- **Basic shift:** req0 a=4'b1101, a_t=0, b=2, b_t=0. Required: `rsp_valid` 3 edges after accept, `rsp_c` = 4'b0011, `rsp_c_t` = 0, `rsp_id` = 0.
- **Taint and zero shift:** req1 a=4'b1010, a_t=32'h1, b=0, b_t=32'h100. Required: `rsp_c` = 4'b1010, `rsp_c_t` = 32'h101, `rsp_id` = 1, 1 edge after accept.
- **Clamp:** req0 b=4'd15, a=4'hF. Required: `rsp_c` = 0, `rsp_valid` 5 edges after accept.
- **Fairness under contention:** both requesters valid continuously, `rsp_ready` = 1. Required grant order 0, 1, 0, 1, with `rsp_id` alternating.
- **Backpressure and mid-op reset:**
  - Hold `rsp_ready` = 0 for 4 cycles. Required: outputs stable, no new accept.
  - Then start a new op and pulse `rst_n` low during SHIFT. Required: no response, state IDLE.
